sad_min_tree: RTL and testbench
===============================

Name: sad_min_tree

Overview:
- Pipelined, parametrised minimum-SAD reduction block for the VBSME motion-estimation datapath.
- Each beat it accepts NUM_IN candidate SAD/index pairs and reduces them to the minimum through a registered binary compare tree.
- Keeps a running minimum across all beats of a search frame (in_first..in_last) and emits the frame-best SAD and index as a single-cycle pulse.

Parameters:
- NUM_IN, 8: candidates per beat; power of two, >= 2.
- SAD_W, 32: SAD width, unsigned.
- IDX_W, 32: candidate index width, opaque payload.
- CNT_W, 16: beat counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid; no backpressure, one beat accepted per cycle when high.
- in_first  in  1  first beat of a frame; qualified by in_valid.
- in_last  in  1  last beat of a frame; qualified by in_valid.
- sad_in  in  NUM_IN*SAD_W  candidate SADs; lane k at bits [k*SAD_W +: SAD_W].
- idx_in  in  NUM_IN*IDX_W  candidate indices, same packing as sad_in.
- out_valid  out  1  one-cycle pulse; frame result valid.
- best_sad  out  SAD_W  frame minimum SAD.
- best_idx  out  IDX_W  index of frame minimum.
- beat_cnt  out  CNT_W  beats merged into the reported frame, saturating.
- busy  out  1  any pipeline stage valid or frame open.

Behaviour:
- Tree: LEVELS = log2(NUM_IN) registered stages. Each stage compares adjacent pairs (2j, 2j+1) and carries sad, idx, valid, first and last.
- Tie rule at every node: if the lower lane's SAD is <= the higher lane's SAD, the lower lane wins. The earliest lane wins on equality.
- Accumulator stage (one more register) with state ACC_EMPTY / ACC_OPEN:
  - ACC_EMPTY + beat arrives: load the beat result, set beat count to 1, go to ACC_OPEN. This applies even if first=0, so a stray beat starts a frame.
  - ACC_OPEN + beat with first=1: discard the running value and reload from the beat. Count restarts at 1.
  - ACC_OPEN + beat with first=0: replace the running value only if beat SAD < running SAD (strict). Earlier beat wins ties. Count +1, saturating at 2^CNT_W-1.
  - Any beat with last=1: after the update, drive out_valid=1 for one cycle with the updated value and count, then go to ACC_EMPTY.
  - first=1 and last=1 on the same beat: single-beat frame; result is that beat's minimum.
- Latency: out_valid asserts exactly LEVELS+1 cycles after the in_valid cycle that carries in_last. Throughput is one beat per cycle with back-to-back frames; frame N's last beat may be followed directly by frame N+1's first beat.
- When out_valid=0, best_sad/best_idx/beat_cnt hold their last reported values.
- SAD compare is unsigned at full SAD_W; no arithmetic, no width growth.
- Reset (async, any time, including mid-frame): all pipeline valid bits=0, accumulator ACC_EMPTY, out_valid=0, best_sad={SAD_W{1}}, best_idx=0, beat_cnt=0, busy=0. In-flight beats are dropped.
- in_first/in_last are ignored when in_valid=0.
- busy = OR of stage valids, OR ACC_OPEN.

Test Plan:
Bench configuration: NUM_IN=4, SAD_W=16, IDX_W=8 (LEVELS=2, latency 3).
- Single beat, first=last=1, SADs {40,12,33,90}, idx {0,1,2,3} -> 3 cycles later out_valid pulse, best_sad=12, best_idx=1, beat_cnt=1.
- Tie in tree: SADs {7,7,7,7}, idx {10,11,12,13} -> best_idx=10. Across beats: beat A min 5 idx 20, beat B min 5 idx 30 -> best_idx=20.
- Three-beat frame with beat minima 50, 9, 17, streamed back-to-back -> one pulse, best_sad=9, idx of beat 2, beat_cnt=3. out_valid is never high on the non-last beats.
- Back-to-back frames: frame 1 {last on cycle t, min 4}, frame 2 starts at t+1 with min 100 -> pulses at t+3 (4) and frame 2's last+3 (100). Frame 2 is not contaminated by 4.
- Rst pulsed mid-frame after 2 beats, then a new single-beat frame min 60 -> only that frame reports, 60, beat_cnt=1. During reset: best_sad=0xFFFF, out_valid=0, busy=0.
- in_first re-asserted mid-frame (beats min 3, then first=1 min 70, last) -> best_sad=70, beat_cnt=1.

Source files
------------

// File: rtl/sad_min_tree.sv
// Pipelined minimum-SAD reduction: registered binary compare tree over NUM_IN lanes,
// followed by a frame accumulator that reports the frame-best SAD/index on in_last.
module sad_min_tree #(
  parameter int NUM_IN = 8,
  parameter int SAD_W  = 32,
  parameter int IDX_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [NUM_IN*SAD_W-1:0]  sad_in,
  input  logic [NUM_IN*IDX_W-1:0]  idx_in,
  output logic                     out_valid,
  output logic [SAD_W-1:0]         best_sad,
  output logic [IDX_W-1:0]         best_idx,
  output logic [CNT_W-1:0]         beat_cnt,
  output logic                     busy
);

  localparam int unsigned LEVELS = $clog2(NUM_IN);

  typedef enum logic {ACC_EMPTY, ACC_OPEN} acc_state_t;

  logic [LEVELS-1:0] stage_v;
  logic              t_v, t_f, t_l;
  logic [SAD_W-1:0]  t_sad;
  logic [IDX_W-1:0]  t_idx;

  genvar gl;
  for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
    localparam int unsigned NI = NUM_IN >> gl;
    localparam int unsigned NO = NI / 2;

    logic [NI*SAD_W-1:0] sad_d;
    logic [NI*IDX_W-1:0] idx_d;
    logic                v_d, f_d, l_d;
    logic [NO*SAD_W-1:0] sad_n, sad_q;
    logic [NO*IDX_W-1:0] idx_n, idx_q;
    logic                v_q, f_q, l_q;

    if (gl == 0) begin : g_src
      assign sad_d = sad_in;
      assign idx_d = idx_in;
      assign v_d   = in_valid;
      assign f_d   = in_first;
      assign l_d   = in_last;
    end else begin : g_src
      assign sad_d = g_lvl[gl-1].sad_q;
      assign idx_d = g_lvl[gl-1].idx_q;
      assign v_d   = g_lvl[gl-1].v_q;
      assign f_d   = g_lvl[gl-1].f_q;
      assign l_d   = g_lvl[gl-1].l_q;
    end

    // Lower lane wins on equality so the earliest candidate survives ties.
    always_comb begin
      sad_n = '0;
      idx_n = '0;
      for (int unsigned j = 0; j < NO; j++) begin
        if (sad_d[2*j*SAD_W +: SAD_W] <= sad_d[(2*j+1)*SAD_W +: SAD_W]) begin
          sad_n[j*SAD_W +: SAD_W] = sad_d[2*j*SAD_W +: SAD_W];
          idx_n[j*IDX_W +: IDX_W] = idx_d[2*j*IDX_W +: IDX_W];
        end else begin
          sad_n[j*SAD_W +: SAD_W] = sad_d[(2*j+1)*SAD_W +: SAD_W];
          idx_n[j*IDX_W +: IDX_W] = idx_d[(2*j+1)*IDX_W +: IDX_W];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        f_q   <= 1'b0;
        l_q   <= 1'b0;
        sad_q <= '0;
        idx_q <= '0;
      end else begin
        v_q   <= v_d;
        f_q   <= v_d & f_d;
        l_q   <= v_d & l_d;
        sad_q <= sad_n;
        idx_q <= idx_n;
      end
    end

    assign stage_v[gl] = v_q;
  end

  assign t_v   = g_lvl[LEVELS-1].v_q;
  assign t_f   = g_lvl[LEVELS-1].f_q;
  assign t_l   = g_lvl[LEVELS-1].l_q;
  assign t_sad = g_lvl[LEVELS-1].sad_q;
  assign t_idx = g_lvl[LEVELS-1].idx_q;

  acc_state_t       state_q, state_n;
  logic [SAD_W-1:0] run_sad_q, run_sad_n;
  logic [IDX_W-1:0] run_idx_q, run_idx_n;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_n;
  logic             ov_n;
  logic [SAD_W-1:0] bs_n;
  logic [IDX_W-1:0] bi_n;
  logic [CNT_W-1:0] bc_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACC_EMPTY;
      run_sad_q <= '1;
      run_idx_q <= '0;
      run_cnt_q <= '0;
      out_valid <= 1'b0;
      best_sad  <= '1;
      best_idx  <= '0;
      beat_cnt  <= '0;
    end else begin
      state_q   <= state_n;
      run_sad_q <= run_sad_n;
      run_idx_q <= run_idx_n;
      run_cnt_q <= run_cnt_n;
      out_valid <= ov_n;
      best_sad  <= bs_n;
      best_idx  <= bi_n;
      beat_cnt  <= bc_n;
    end
  end

  // The reported value is the post-update running value, so the last beat participates.
  always_comb begin
    state_n   = state_q;
    run_sad_n = run_sad_q;
    run_idx_n = run_idx_q;
    run_cnt_n = run_cnt_q;
    ov_n      = 1'b0;
    bs_n      = best_sad;
    bi_n      = best_idx;
    bc_n      = beat_cnt;
    if (t_v) begin
      if (state_q == ACC_EMPTY || t_f) begin
        run_sad_n = t_sad;
        run_idx_n = t_idx;
        run_cnt_n = CNT_W'(1);
      end else begin
        if (t_sad < run_sad_q) begin
          run_sad_n = t_sad;
          run_idx_n = t_idx;
        end
        if (run_cnt_q != '1) run_cnt_n = run_cnt_q + CNT_W'(1);
      end
      if (t_l) begin
        ov_n    = 1'b1;
        bs_n    = run_sad_n;
        bi_n    = run_idx_n;
        bc_n    = run_cnt_n;
        state_n = ACC_EMPTY;
      end else begin
        state_n = ACC_OPEN;
      end
    end
  end

  assign busy = (|stage_v) | (state_q == ACC_OPEN);

endmodule

// File: tb/tb_sad_min_tree.sv
// Scoreboard bench for sad_min_tree: frame-level reference model queues expected
// results at issue time; a negedge monitor checks pulses, latency and held outputs.
module tb_sad_min_tree;
  localparam int NUM_IN = 4;
  localparam int SAD_W  = 16;
  localparam int IDX_W  = 8;
  localparam int CNT_W  = 4;
  localparam int LAT    = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid, in_first, in_last;
  logic [NUM_IN*SAD_W-1:0] sad_in;
  logic [NUM_IN*IDX_W-1:0] idx_in;
  logic                    out_valid;
  logic [SAD_W-1:0]        best_sad;
  logic [IDX_W-1:0]        best_idx;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    busy;

  sad_min_tree #(.NUM_IN(NUM_IN), .SAD_W(SAD_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .sad_in(sad_in), .idx_in(idx_in), .out_valid(out_valid), .best_sad(best_sad),
    .best_idx(best_idx), .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SAD_W-1:0] sad;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    int               at;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Frame-level reference state.
  bit               m_open = 1'b0;
  logic [SAD_W-1:0] m_sad;
  logic [IDX_W-1:0] m_idx;
  int               m_cnt;
  logic [SAD_W-1:0] h_sad = '1;
  logic [IDX_W-1:0] h_idx = '0;
  logic [CNT_W-1:0] h_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [31:0] i4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic send(input logic [63:0] s, input logic [31:0] ix, input bit f, input bit l);
    int               bk;
    logic [SAD_W-1:0] bs;
    logic [IDX_W-1:0] bi;
    exp_t             e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_first = f; in_last = l; sad_in = s; idx_in = ix;
    bk = 0;
    for (int k = 1; k < NUM_IN; k++)
      if (s[k*SAD_W +: SAD_W] < s[bk*SAD_W +: SAD_W]) bk = k;
    bs = s[bk*SAD_W +: SAD_W];
    bi = ix[bk*IDX_W +: IDX_W];
    if (!m_open || f) begin
      m_sad = bs; m_idx = bi; m_cnt = 1;
    end else begin
      if (bs < m_sad) begin m_sad = bs; m_idx = bi; end
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    m_open = 1'b1;
    if (l) begin
      e.sad = m_sad; e.idx = m_idx; e.cnt = CNT_W'(m_cnt); e.at = cyc + LAT;
      expq.push_back(e);
      m_open = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      sad_in   = {$urandom, $urandom};
      idx_in   = $urandom;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_best_sad", 64'(best_sad), 64'hFFFF);
    check("rst_best_idx", 64'(best_idx), 0);
    check("rst_beat_cnt", 64'(beat_cnt), 0);
    m_open = 1'b0;
    expq.delete();
    h_sad = '1; h_idx = '0; h_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got out_valid=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          check("pulse_cycle", 64'(cyc), 64'(e.at));
          check("best_sad", 64'(best_sad), 64'(e.sad));
          check("best_idx", 64'(best_idx), 64'(e.idx));
          check("beat_cnt", 64'(beat_cnt), 64'(e.cnt));
          h_sad = e.sad; h_idx = e.idx; h_cnt = e.cnt;
        end
      end else begin
        check("hold_sad", 64'(best_sad), 64'(h_sad));
        check("hold_idx", 64'(best_idx), 64'(h_idx));
        check("hold_cnt", 64'(beat_cnt), 64'(h_cnt));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; sad_in = '0; idx_in = '0;
    do_reset();
    idle(2);

    send(p4(40, 12, 33, 90), i4(0, 1, 2, 3), 1, 1);
    send(p4(7, 7, 7, 7), i4(10, 11, 12, 13), 1, 1);
    send(p4(9, 5, 8, 6), i4(21, 20, 22, 23), 1, 0);
    send(p4(5, 9, 9, 9), i4(30, 31, 32, 33), 0, 1);
    send(p4(50, 60, 70, 80), i4(1, 2, 3, 4), 1, 0);
    send(p4(20, 9, 11, 30), i4(5, 6, 7, 8), 0, 0);
    send(p4(17, 40, 18, 19), i4(9, 10, 11, 12), 0, 1);
    send(p4(8, 4, 6, 5), i4(40, 41, 42, 43), 1, 1);
    send(p4(200, 150, 100, 101), i4(50, 51, 52, 53), 1, 0);
    send(p4(300, 301, 302, 303), i4(54, 55, 56, 57), 0, 1);
    idle(5);
    check("idle_busy", 64'(busy), 0);

    send(p4(1, 2, 3, 4), i4(60, 61, 62, 63), 1, 0);
    send(p4(2, 2, 2, 2), i4(64, 65, 66, 67), 0, 0);
    @(negedge clk);
    check("open_busy", 64'(busy), 1);
    do_reset();
    send(p4(60, 61, 62, 63), i4(70, 71, 72, 73), 1, 1);

    send(p4(3, 30, 31, 32), i4(80, 81, 82, 83), 1, 0);
    send(p4(70, 71, 72, 73), i4(84, 85, 86, 87), 1, 1);

    for (int b = 0; b < 20; b++)
      send(p4(100 - b, 200, 200, 200), i4(b, 99, 99, 99), b == 0, b == 19);
    send(p4(9, 9, 9, 9), i4(1, 2, 3, 4), 0, 1);

    for (int fr = 0; fr < 40; fr++) begin
      int len;
      len = int'($urandom_range(1, 5));
      for (int b = 0; b < len; b++) begin
        bit f;
        f = (b == 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 7) == 0);
        send({$urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31)} >> 0 == 0 ? '0 :
             p4(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31))),
             $urandom, f, b == len - 1);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(8);
    check("queue_drained", 64'(expq.size()), 0);
    check("final_busy", 64'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
